// File: rtl/tour_cmd_arbiter_if.sv
// Bundle of the UART-side, solver-side and cmd_proc-side signals around the
// tour command arbiter. The master modport is the arbiter itself; the slave
// modport is everything around it (UART wrapper, solver, cmd_proc).
interface tour_cmd_arbiter_if #(
  parameter int IDX_W = 5
);
  logic [15:0]      cmd_UART;
  logic             cmd_rdy_UART;
  logic             clr_cmd_rdy_UART;
  logic             start_tour;
  logic [7:0]       move;
  logic [IDX_W-1:0] mv_indx;
  logic [15:0]      cmd;
  logic             cmd_rdy;
  logic             clr_cmd_rdy;
  logic             send_resp;
  logic [7:0]       resp;

  modport master (
    input  cmd_UART, cmd_rdy_UART, start_tour, move, clr_cmd_rdy, send_resp,
    output clr_cmd_rdy_UART, mv_indx, cmd, cmd_rdy, resp
  );

  modport slave (
    output cmd_UART, cmd_rdy_UART, start_tour, move, clr_cmd_rdy, send_resp,
    input  clr_cmd_rdy_UART, mv_indx, cmd, cmd_rdy, resp
  );
endinterface

// File: rtl/tour_cmd_arbiter.sv
// Tour command arbiter: passes UART commands to cmd_proc while idle, and on
// start_tour replays the solved knight's tour as vertical/horizontal leg
// command pairs, handshaking each one with cmd_proc.
module tour_cmd_arbiter #(
  parameter int NUM_MOVES = 24,
  parameter int IDX_W     = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  tour_cmd_arbiter_if.master    bus
);

  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_W = 8'h3F;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_E = 8'hBF;
  localparam logic [3:0] OP_VERT = 4'h4;
  localparam logic [3:0] OP_HORZ = 4'h5;
  localparam logic [7:0] RESP_DONE = 8'hA5;
  localparam logic [7:0] RESP_BUSY = 8'h5A;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    VERT  = 3'd1,
    VWAIT = 3'd2,
    HORZ  = 3'd3,
    HWAIT = 3'd4
  } state_t;

  state_t           state_r, next_state_s;
  logic [IDX_W-1:0] mv_indx_r, next_mv_indx_s;
  logic [15:0]      vert_cmd_s, horz_cmd_s;
  logic             last_move_s;

  // Vertical leg of a knight move; the lowest set bit wins, and an empty
  // move still yields a zero-length northward leg.
  function automatic logic [15:0] vert_leg_f(input logic [7:0] mv);
    logic [7:0] hdg;
    logic [3:0] sq;
    if      (mv[0]) begin hdg = HDG_N; sq = 4'd2; end
    else if (mv[1]) begin hdg = HDG_N; sq = 4'd2; end
    else if (mv[2]) begin hdg = HDG_N; sq = 4'd1; end
    else if (mv[3]) begin hdg = HDG_S; sq = 4'd1; end
    else if (mv[4]) begin hdg = HDG_S; sq = 4'd2; end
    else if (mv[5]) begin hdg = HDG_S; sq = 4'd2; end
    else if (mv[6]) begin hdg = HDG_S; sq = 4'd1; end
    else if (mv[7]) begin hdg = HDG_N; sq = 4'd1; end
    else            begin hdg = HDG_N; sq = 4'd0; end
    return {OP_VERT, hdg, sq};
  endfunction

  // Horizontal (fanfare) leg of a knight move; same priority rule, and an
  // empty move yields a zero-length westward leg.
  function automatic logic [15:0] horz_leg_f(input logic [7:0] mv);
    logic [7:0] hdg;
    logic [3:0] sq;
    if      (mv[0]) begin hdg = HDG_E; sq = 4'd1; end
    else if (mv[1]) begin hdg = HDG_W; sq = 4'd1; end
    else if (mv[2]) begin hdg = HDG_W; sq = 4'd2; end
    else if (mv[3]) begin hdg = HDG_W; sq = 4'd2; end
    else if (mv[4]) begin hdg = HDG_W; sq = 4'd1; end
    else if (mv[5]) begin hdg = HDG_E; sq = 4'd1; end
    else if (mv[6]) begin hdg = HDG_E; sq = 4'd2; end
    else if (mv[7]) begin hdg = HDG_E; sq = 4'd2; end
    else            begin hdg = HDG_W; sq = 4'd0; end
    return {OP_HORZ, hdg, sq};
  endfunction

  assign vert_cmd_s  = vert_leg_f(bus.move);
  assign horz_cmd_s  = horz_leg_f(bus.move);
  assign last_move_s = (mv_indx_r == LAST_IDX);
  assign bus.mv_indx = mv_indx_r;

  // State and move-index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      mv_indx_r <= '0;
    end else begin
      state_r   <= next_state_s;
      mv_indx_r <= next_mv_indx_s;
    end
  end

  // Next-state logic and command/handshake outputs from the current state.
  always_comb begin
    next_state_s         = state_r;
    next_mv_indx_s       = mv_indx_r;
    bus.cmd              = bus.cmd_UART;
    bus.cmd_rdy          = 1'b0;
    bus.clr_cmd_rdy_UART = 1'b0;
    bus.resp             = RESP_BUSY;
    case (state_r)
      IDLE: begin
        bus.cmd              = bus.cmd_UART;
        bus.cmd_rdy          = bus.cmd_rdy_UART;
        bus.clr_cmd_rdy_UART = bus.clr_cmd_rdy;
        bus.resp             = RESP_DONE;
        if (bus.start_tour) begin
          next_state_s   = VERT;
          next_mv_indx_s = '0;
        end else begin
          next_state_s   = IDLE;
        end
      end
      VERT: begin
        bus.cmd     = vert_cmd_s;
        bus.cmd_rdy = 1'b1;
        if (bus.clr_cmd_rdy) begin
          next_state_s = VWAIT;
        end else begin
          next_state_s = VERT;
        end
      end
      VWAIT: begin
        bus.cmd = vert_cmd_s;
        if (bus.send_resp) begin
          next_state_s = HORZ;
        end else begin
          next_state_s = VWAIT;
        end
      end
      HORZ: begin
        bus.cmd     = horz_cmd_s;
        bus.cmd_rdy = 1'b1;
        if (bus.clr_cmd_rdy) begin
          next_state_s = HWAIT;
        end else begin
          next_state_s = HORZ;
        end
      end
      HWAIT: begin
        bus.cmd = horz_cmd_s;
        if (last_move_s) begin
          bus.resp = RESP_DONE;
        end else begin
          bus.resp = RESP_BUSY;
        end
        if (bus.send_resp && last_move_s) begin
          next_state_s   = IDLE;
          next_mv_indx_s = '0;
        end else if (bus.send_resp) begin
          next_state_s   = VERT;
          next_mv_indx_s = mv_indx_r + IDX_W'(1);
        end else begin
          next_state_s   = HWAIT;
        end
      end
      default: begin
        next_state_s   = IDLE;
        next_mv_indx_s = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_tour_cmd_arbiter.sv
// Directed self-checking bench for tour_cmd_arbiter. Inputs change 1 time
// unit after the rising edge; outputs are checked a further unit later.
module tb_tour_cmd_arbiter;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  tour_cmd_arbiter_if #(.IDX_W(5)) bus ();

  logic [7:0] move_drv;
  logic       use_mem;
  logic [7:0] move_mem [32];
  logic [15:0] exp_vert [9];
  logic [15:0] exp_horz [9];

  assign bus.move = use_mem ? move_mem[bus.mv_indx] : move_drv;

  tour_cmd_arbiter #(.NUM_MOVES(24), .IDX_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    bus.clr_cmd_rdy = 1'b1;
    step();
    bus.clr_cmd_rdy = 1'b0;
    #1;
  endtask

  task automatic pulse_send();
    bus.send_resp = 1'b1;
    step();
    bus.send_resp = 1'b0;
    #1;
  endtask

  task automatic pulse_start();
    bus.start_tour = 1'b1;
    step();
    bus.start_tour = 1'b0;
    #1;
  endtask

  // Check one leg pair for the currently presented move, leaving the DUT at
  // VERT of the next move.
  task automatic leg_pair(input string tag, input logic [15:0] v, input logic [15:0] h);
    chk({tag, "_vert"}, 32'(bus.cmd), 32'(v));
    pulse_clr();
    pulse_send();
    chk({tag, "_horz"}, 32'(bus.cmd), 32'(h));
    pulse_clr();
    pulse_send();
  endtask

  initial begin
    int ncmd;
    int idx;
    n_chk = 0;
    n_pass = 0;
    exp_vert = '{16'h4002, 16'h4002, 16'h4001, 16'h47F1, 16'h47F2,
                 16'h47F2, 16'h47F1, 16'h4001, 16'h4000};
    exp_horz = '{16'h5BF1, 16'h53F1, 16'h53F2, 16'h53F2, 16'h53F1,
                 16'h5BF1, 16'h5BF2, 16'h5BF2, 16'h53F0};
    for (int i = 0; i < 32; i++) move_mem[i] = 8'h00;
    for (int i = 0; i < 24; i++) move_mem[i] = 8'h01 << (i % 8);
    use_mem = 1'b0;
    move_drv = 8'h00;
    rst_n = 1'b0;
    bus.cmd_UART = 16'h0000;
    bus.cmd_rdy_UART = 1'b0;
    bus.start_tour = 1'b0;
    bus.clr_cmd_rdy = 1'b0;
    bus.send_resp = 1'b0;

    // 1: reset state
    step();
    step();
    chk("rst_cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
    chk("rst_mv_indx", 32'(bus.mv_indx), 32'd0);
    chk("rst_resp", 32'(bus.resp), 32'hA5);
    chk("rst_clr_uart", 32'(bus.clr_cmd_rdy_UART), 32'd0);
    rst_n = 1'b1;
    step();

    // 2: UART passthrough
    bus.cmd_UART = 16'h2000;
    bus.cmd_rdy_UART = 1'b1;
    #1;
    chk("pt_cmd", 32'(bus.cmd), 32'h2000);
    chk("pt_cmd_rdy", 32'(bus.cmd_rdy), 32'd1);
    bus.clr_cmd_rdy = 1'b1;
    #1;
    chk("pt_clr_uart_hi", 32'(bus.clr_cmd_rdy_UART), 32'd1);
    step();
    bus.clr_cmd_rdy = 1'b0;
    bus.cmd_rdy_UART = 1'b0;
    #1;
    chk("pt_clr_uart_lo", 32'(bus.clr_cmd_rdy_UART), 32'd0);
    chk("pt_cmd_rdy_lo", 32'(bus.cmd_rdy), 32'd0);

    // 3: first move of a tour, move=01
    move_drv = 8'h01;
    pulse_start();
    chk("t3_vert_cmd", 32'(bus.cmd), 32'h4002);
    chk("t3_vert_rdy", 32'(bus.cmd_rdy), 32'd1);
    chk("t3_mv0", 32'(bus.mv_indx), 32'd0);
    pulse_clr();
    chk("t3_vwait_rdy", 32'(bus.cmd_rdy), 32'd0);
    chk("t3_vwait_cmd", 32'(bus.cmd), 32'h4002);
    chk("t3_vwait_resp", 32'(bus.resp), 32'h5A);
    pulse_send();
    chk("t3_horz_cmd", 32'(bus.cmd), 32'h5BF1);
    chk("t3_horz_rdy", 32'(bus.cmd_rdy), 32'd1);
    pulse_clr();
    chk("t3_hwait_resp", 32'(bus.resp), 32'h5A);
    pulse_send();
    chk("t3_mv1", 32'(bus.mv_indx), 32'd1);
    chk("t3_next_rdy", 32'(bus.cmd_rdy), 32'd1);

    // 4: other move decodes (mv_indx 1..4)
    move_drv = 8'h10;
    #1;
    leg_pair("m10", 16'h47F2, 16'h53F1);
    move_drv = 8'h04;
    #1;
    leg_pair("m04", 16'h4001, 16'h53F2);
    move_drv = 8'h00;
    #1;
    leg_pair("m00", 16'h4000, 16'h53F0);
    move_drv = 8'h0C;
    #1;
    leg_pair("m0C", 16'h4001, 16'h53F2);
    chk("t4_mv5", 32'(bus.mv_indx), 32'd5);

    // 6: ignored start_tour in VWAIT (move 5), clr+send together in VERT (move 6)
    move_drv = 8'h80;
    pulse_clr();
    pulse_start();
    chk("ign_start_mv", 32'(bus.mv_indx), 32'd5);
    chk("ign_start_rdy", 32'(bus.cmd_rdy), 32'd0);
    chk("ign_start_cmd", 32'(bus.cmd), 32'h4001);
    pulse_send();
    chk("ign_start_horz", 32'(bus.cmd), 32'h5BF2);
    pulse_clr();
    pulse_send();
    bus.clr_cmd_rdy = 1'b1;
    bus.send_resp = 1'b1;
    step();
    bus.clr_cmd_rdy = 1'b0;
    bus.send_resp = 1'b0;
    step();
    chk("both_vwait_rdy", 32'(bus.cmd_rdy), 32'd0);
    chk("both_vwait_cmd", 32'(bus.cmd), 32'h4001);
    pulse_send();
    pulse_clr();
    pulse_send();
    // move 7: stop in HWAIT, then reset
    pulse_clr();
    pulse_send();
    pulse_clr();
    chk("hw7_mv", 32'(bus.mv_indx), 32'd7);
    chk("hw7_resp", 32'(bus.resp), 32'h5A);
    bus.cmd_UART = 16'h3333;
    rst_n = 1'b0;
    #1;
    chk("rst7_mv", 32'(bus.mv_indx), 32'd0);
    chk("rst7_cmd", 32'(bus.cmd), 32'h3333);
    chk("rst7_resp", 32'(bus.resp), 32'hA5);
    chk("rst7_rdy", 32'(bus.cmd_rdy), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // 5: full tour from the move memory with a scripted cmd_proc
    use_mem = 1'b1;
    bus.cmd_UART = 16'h0000;
    ncmd = 0;
    pulse_start();
    for (int i = 0; i < 24; i++) begin
      idx = i % 8;
      if (i == 10) begin
        bus.cmd_UART = 16'h1234;
        bus.cmd_rdy_UART = 1'b1;
        #1;
      end
      if (bus.cmd_rdy === 1'b1) ncmd++;
      chk($sformatf("tour_v%0d", i), 32'(bus.cmd), 32'(exp_vert[idx]));
      chk($sformatf("tour_mv%0d", i), 32'(bus.mv_indx), 32'(i));
      pulse_clr();
      pulse_send();
      if (bus.cmd_rdy === 1'b1) ncmd++;
      chk($sformatf("tour_h%0d", i), 32'(bus.cmd), 32'(exp_horz[idx]));
      pulse_clr();
      chk($sformatf("tour_clru%0d", i), 32'(bus.clr_cmd_rdy_UART), 32'd0);
      chk($sformatf("tour_resp%0d", i), 32'(bus.resp), (i == 23) ? 32'hA5 : 32'h5A);
      pulse_send();
    end
    chk("tour_ncmd", 32'(ncmd), 32'd48);
    chk("tour_end_mv", 32'(bus.mv_indx), 32'd0);
    chk("tour_end_resp", 32'(bus.resp), 32'hA5);
    chk("tour_uart_cmd", 32'(bus.cmd), 32'h1234);
    chk("tour_uart_rdy", 32'(bus.cmd_rdy), 32'd1);
    bus.clr_cmd_rdy = 1'b1;
    #1;
    chk("tour_uart_clr", 32'(bus.clr_cmd_rdy_UART), 32'd1);
    step();
    bus.clr_cmd_rdy = 1'b0;
    bus.cmd_rdy_UART = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
